uart_gen2: RTL
==============

UART_GEN2 -- requirements
Module: uart_gen2

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame (legal 5..9).
REQ-002 Parameter FIFO_W, default 4, FIFO address width; TX and RX FIFO depth is 2^FIFO_W each.
REQ-003 Parameter DVSR_W, default 16, width of the runtime baud divisor.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 dvsr  input  DVSR_W  16x oversample tick period minus one (tick every dvsr+1 clocks).
REQ-007 par_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 wr_uart  input  1  push w_data into TX FIFO.
REQ-010 w_data  input  DBIT  transmit word.
REQ-011 rd_uart  input  1  pop RX FIFO head.
REQ-012 rx  input  1  serial input, asynchronous, idle high.
REQ-013 err_clr  input  1  clears all four sticky error flags.
REQ-014 tx  output  1  serial output, idle high.
REQ-015 tx_full / rx_empty  output  1 each  TX FIFO full / RX FIFO empty.
REQ-016 r_data  output  DBIT  RX FIFO head, first-word fall-through.
REQ-017 tx_done_tick / rx_done_tick  output  1 each  one-clock frame-complete pulses.
REQ-018 e_parity / e_frame / e_rxof / e_txof  output  1 each  sticky error flags.

Function
REQ-019 Baud generator SHALL count 0..dvsr, pulse tick when count==dvsr, then wrap to 0; dvsr=0 gives tick every clock; a dvsr change takes effect at the next wrap.
REQ-020 TX and RX SHALL each latch par_mode and stop2 at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-021 TX FSM states: IDLE, START, DATA, PARITY, STOP; every bit lasts 16 ticks; data is sent LSB first.
REQ-022 TX SHALL leave IDLE on the first tick with the TX FIFO non-empty, pop the word, and drive tx low in the same cycle.
REQ-023 PARITY SHALL be skipped when par_mode is none; even mode sends XOR of data bits, odd mode sends its inverse.
REQ-024 STOP SHALL hold tx high for 16 ticks (32 if stop2), then pulse tx_done_tick for one clock and return to IDLE.
REQ-025 rx SHALL pass a two-flop synchroniser before use.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised rx low.
REQ-027 START SHALL resample at tick 7; if rx is high, return to IDLE with no tick and no push (glitch reject).
REQ-028 Data, parity and first stop bit SHALL each be sampled 16 ticks after the previous sample point (bit centre).
REQ-029 Parity mismatch SHALL set e_parity; stop sample of 0 SHALL set e_frame; the word SHALL still be pushed.
REQ-030 After the first stop sample, RX SHALL pulse rx_done_tick, push the word and return to IDLE; the second stop bit is not checked.
REQ-031 A push into a full RX FIFO SHALL discard the incoming word and set e_rxof; existing contents are unchanged.
REQ-032 wr_uart while tx_full SHALL be ignored and set e_txof; rd_uart while rx_empty SHALL be ignored with no flag.
REQ-033 Simultaneous read and write on a full or empty FIFO SHALL both take effect; occupancy is unchanged.
REQ-034 err_clr and an error event in the same cycle SHALL leave the flag set.
REQ-035 r_data SHALL be don't-care while rx_empty=1.

Reset
REQ-036 reset low SHALL immediately force: tx=1, tx_full=0, rx_empty=1, both ticks 0, all error flags 0, both FSMs IDLE, FIFOs empty, baud counter 0.
REQ-037 reset mid-frame SHALL abort the frame; after release, no partial word SHALL appear in either FIFO.

Verification
REQ-038 Loopback (tx->rx), dvsr=162, 8N1, write 0xAE -> tx low for 2608 clocks, then 0,1,1,1,0,1,0,1, stop high; rx_done_tick; r_data=0xAE; no errors.
REQ-039 Even parity, 0xAE -> parity bit 1; receiver set to odd -> e_parity=1, r_data=0xAE; err_clr -> e_parity=0.
REQ-040 Drive rx low through the stop bit centre -> e_frame=1, rx_done_tick, word pushed.
REQ-041 Write 17 words with FIFO_W=4 without tx draining -> tx_full=1 after 16, e_txof=1; receive 17 frames without rd_uart -> e_rxof=1, first 16 words retained in order.
REQ-042 rx low for 4 ticks then high -> no rx_done_tick, rx_empty stays 1.
REQ-043 Assert reset during TX data bit 3 -> tx=1 within the reset cycle; after release the FIFOs are empty and no rx_done_tick occurs.

Source files
------------

// File: rtl/uart_gen2.sv
// uart_gen2: full-duplex UART with runtime baud divisor, optional parity,
// one or two stop bits, TX/RX FIFOs and sticky error flags.
// Ports:
//   clk, reset (async, active-low)
//   dvsr                16x oversample tick period minus one
//   par_mode, stop2     frame format, latched by TX and RX at frame start
//   wr_uart, w_data     push into TX FIFO; tx_full reports TX FIFO full
//   rd_uart, r_data     pop RX FIFO (first-word fall-through); rx_empty
//   rx, tx              serial lines, idle high
//   tx_done_tick, rx_done_tick   one-clock frame-complete pulses
//   e_parity, e_frame, e_rxof, e_txof   sticky errors, cleared by err_clr
`timescale 1ns/1ps

// Small FIFO with combinational head read so the head word is visible
// without a pop. Pointers carry one extra wrap bit to tell full from empty.
module uart_gen2_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] r_data,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   w_ptr_reg;
    logic [AW:0]   r_ptr_reg;
    logic          wr_en;
    logic          rd_en;

    assign empty = (w_ptr_reg == r_ptr_reg);
    assign full  = (w_ptr_reg[AW] != r_ptr_reg[AW]) &&
                   (w_ptr_reg[AW-1:0] == r_ptr_reg[AW-1:0]);

    // A simultaneous read makes room on full; a simultaneous write supplies
    // the word on empty. Either way both pointers move and occupancy holds.
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && (!empty || wr);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[w_ptr_reg[AW-1:0]] <= w_data;
    end

    assign r_data = mem[r_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
        end else begin
            if (wr_en) w_ptr_reg <= w_ptr_reg + 1'b1;
            if (rd_en) r_ptr_reg <= r_ptr_reg + 1'b1;
        end
    end
endmodule

module uart_gen2 #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 4,
    parameter int DVSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    input  logic              wr_uart,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd_uart,
    input  logic              rx,
    input  logic              err_clr,
    output logic              tx,
    output logic              tx_full,
    output logic              rx_empty,
    output logic [DBIT-1:0]   r_data,
    output logic              tx_done_tick,
    output logic              rx_done_tick,
    output logic              e_parity,
    output logic              e_frame,
    output logic              e_rxof,
    output logic              e_txof
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [3:0] LAST_BIT = 4'(DBIT - 1);

    // ---------------- baud generator ----------------
    // dvsr is captured only on wrap so a new value never strands the count
    // above the compare point.
    logic [DVSR_W-1:0] baud_cnt_reg;
    logic [DVSR_W-1:0] dvsr_reg;
    logic              tick;

    assign tick = (baud_cnt_reg == dvsr_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_reg <= '0;
            dvsr_reg     <= '0;
        end else if (tick) begin
            baud_cnt_reg <= '0;
            dvsr_reg     <= dvsr;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // ---------------- FIFOs ----------------
    logic            tx_empty;
    logic [DBIT-1:0] tx_head;
    logic            tx_pop;
    logic            rx_full;
    logic            rx_push;
    logic [DBIT-1:0] rx_data_reg;

    uart_gen2_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr(wr_uart), .rd(tx_pop),
        .w_data(w_data), .r_data(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_gen2_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr(rx_push), .rd(rd_uart),
        .w_data(rx_data_reg), .r_data(r_data), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- transmitter ----------------
    state_t          tx_state_reg;
    logic [4:0]      tx_s_reg;
    logic [3:0]      tx_n_reg;
    logic [DBIT-1:0] tx_data_reg;
    logic            tx_par_en_reg;
    logic            tx_pbit_reg;
    logic            tx_stop2_reg;
    logic            tx_reg;
    logic            tx_done_reg;

    assign tx_pop = (tx_state_reg == S_IDLE) && tick && !tx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_reg  <= S_IDLE;
            tx_s_reg      <= '0;
            tx_n_reg      <= '0;
            tx_data_reg   <= '0;
            tx_par_en_reg <= 1'b0;
            tx_pbit_reg   <= 1'b0;
            tx_stop2_reg  <= 1'b0;
            tx_reg        <= 1'b1;
            tx_done_reg   <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (tx_state_reg)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_reg        <= 1'b0;
                        tx_data_reg   <= tx_head;
                        // par_mode 01/10 enable parity; bit 1 selects odd
                        tx_par_en_reg <= ^par_mode;
                        tx_pbit_reg   <= (^tx_head) ^ par_mode[1];
                        tx_stop2_reg  <= stop2;
                        tx_s_reg      <= '0;
                        tx_state_reg  <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tx_s_reg == 5'd15) begin
                            tx_s_reg     <= '0;
                            tx_n_reg     <= '0;
                            tx_reg       <= tx_data_reg[0];
                            tx_state_reg <= S_DATA;
                        end else begin
                            tx_s_reg <= tx_s_reg + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tx_s_reg == 5'd15) begin
                            tx_s_reg <= '0;
                            if (tx_n_reg == LAST_BIT) begin
                                if (tx_par_en_reg) begin
                                    tx_reg       <= tx_pbit_reg;
                                    tx_state_reg <= S_PARITY;
                                end else begin
                                    tx_reg       <= 1'b1;
                                    tx_state_reg <= S_STOP;
                                end
                            end else begin
                                tx_n_reg    <= tx_n_reg + 1'b1;
                                tx_reg      <= tx_data_reg[1];
                                tx_data_reg <= tx_data_reg >> 1;
                            end
                        end else begin
                            tx_s_reg <= tx_s_reg + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (tx_s_reg == 5'd15) begin
                            tx_s_reg     <= '0;
                            tx_reg       <= 1'b1;
                            tx_state_reg <= S_STOP;
                        end else begin
                            tx_s_reg <= tx_s_reg + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (tx_s_reg == (tx_stop2_reg ? 5'd31 : 5'd15)) begin
                            tx_done_reg  <= 1'b1;
                            tx_state_reg <= S_IDLE;
                        end else begin
                            tx_s_reg <= tx_s_reg + 1'b1;
                        end
                    end
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic       rx_meta_reg;
    logic       rx_sync_reg;
    state_t     rx_state_reg;
    logic [3:0] rx_s_reg;
    logic [3:0] rx_n_reg;
    logic       rx_par_en_reg;
    logic       rx_podd_reg;
    logic       rx_done_reg;
    logic       e_parity_reg;
    logic       e_frame_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // The word is pushed in the same cycle the stop bit is sampled, so it
    // is visible at r_data while rx_done_tick is high.
    assign rx_push = (rx_state_reg == S_STOP) && tick && (rx_s_reg == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_reg  <= S_IDLE;
            rx_s_reg      <= '0;
            rx_n_reg      <= '0;
            rx_data_reg   <= '0;
            rx_par_en_reg <= 1'b0;
            rx_podd_reg   <= 1'b0;
            rx_done_reg   <= 1'b0;
            e_parity_reg  <= 1'b0;
            e_frame_reg   <= 1'b0;
        end else begin
            rx_done_reg <= 1'b0;
            // Clear first; a same-cycle error below overrides the clear.
            if (err_clr) begin
                e_parity_reg <= 1'b0;
                e_frame_reg  <= 1'b0;
            end
            case (rx_state_reg)
                S_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_s_reg      <= '0;
                        rx_par_en_reg <= ^par_mode;
                        rx_podd_reg   <= par_mode[1];
                        rx_state_reg  <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s_reg == 4'd7) begin
                            rx_s_reg <= '0;
                            rx_n_reg <= '0;
                            // still high at mid start bit: treat as a glitch
                            rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
                        end else begin
                            rx_s_reg <= rx_s_reg + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (rx_s_reg == 4'd15) begin
                            rx_s_reg    <= '0;
                            rx_data_reg <= {rx_sync_reg, rx_data_reg[DBIT-1:1]};
                            if (rx_n_reg == LAST_BIT)
                                rx_state_reg <= rx_par_en_reg ? S_PARITY : S_STOP;
                            else
                                rx_n_reg <= rx_n_reg + 1'b1;
                        end else begin
                            rx_s_reg <= rx_s_reg + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (rx_s_reg == 4'd15) begin
                            rx_s_reg <= '0;
                            if (rx_sync_reg != ((^rx_data_reg) ^ rx_podd_reg))
                                e_parity_reg <= 1'b1;
                            rx_state_reg <= S_STOP;
                        end else begin
                            rx_s_reg <= rx_s_reg + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (rx_s_reg == 4'd15) begin
                            if (!rx_sync_reg)
                                e_frame_reg <= 1'b1;
                            rx_done_reg  <= 1'b1;
                            rx_state_reg <= S_IDLE;
                        end else begin
                            rx_s_reg <= rx_s_reg + 1'b1;
                        end
                    end
                end
                default: rx_state_reg <= S_IDLE;
            endcase
        end
    end

    // ---------------- overflow flags ----------------
    logic e_rxof_reg;
    logic e_txof_reg;
    logic rxof_ev;
    logic txof_ev;

    assign rxof_ev = rx_push && rx_full && !rd_uart;
    assign txof_ev = wr_uart && tx_full && !tx_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rxof_reg <= 1'b0;
            e_txof_reg <= 1'b0;
        end else begin
            if (err_clr) begin
                e_rxof_reg <= 1'b0;
                e_txof_reg <= 1'b0;
            end
            if (rxof_ev) e_rxof_reg <= 1'b1;
            if (txof_ev) e_txof_reg <= 1'b1;
        end
    end

    assign tx           = tx_reg;
    assign tx_done_tick = tx_done_reg;
    assign rx_done_tick = rx_done_reg;
    assign e_parity     = e_parity_reg;
    assign e_frame      = e_frame_reg;
    assign e_rxof       = e_rxof_reg;
    assign e_txof       = e_txof_reg;
endmodule
